fp_mul_result_stage: RTL
========================

Name: fp_mul_result_stage

Overview:
- Registered, flow-controlled back end for the single-precision Vedic floating-point multiplier.
- Consumes the multiplier's raw 32-bit product together with the original operands.
- Applies IEEE-754 special-case and range handling that the combinational datapath does not perform: NaN, infinity, zero, flush of denormals, overflow and underflow.
- Delivers the corrected result and exception flags through a 2-stage valid/ready pipeline.

Parameters:
- QNAN_PATTERN, 32'h7FC00000, canonical quiet NaN emitted on any invalid result.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and raw product valid.
- in_ready  output  1  stage can accept the current input.
- op_a  input  32  operand A (IEEE single).
- op_b  input  32  operand B (IEEE single).
- raw_prod  input  32  multiplier output for op_a × op_b; same cycle as the operands.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- result  output  32  corrected product.
- flags  output  4  {invalid, overflow, underflow, denorm_flush}, aligned with result.

Behaviour:
- Reset:
  - out_valid=0, result=0, flags=0.
  - Both stage valid bits are cleared.
  - Reset mid-operation discards all in-flight data; no partial output appears afterwards.
- Transfers: an input is accepted when in_valid&&in_ready; an output is consumed when out_valid&&out_ready.
- Pipeline:
  - S1 registers the operands, raw_prod and the classification.
  - S2 computes the override and registers result/flags; outputs are driven directly from the S2 registers.
  - Latency is 2 cycles from acceptance to out_valid when there is no backpressure; sustained throughput is 1 per cycle.
- Flow control:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational).
  - Results are strictly in order. No loss or duplication under any out_ready pattern.
  - With out_ready low, at most 2 transactions are held and in_ready drops.
- Simultaneous accept and consume in the same cycle: data shifts through with no bubble.
- Classification, per operand (exponent e, mantissa m):
  - zero: e==0 && m==0.
  - denorm: e==0 && m!=0, flushed to zero.
  - inf: e==255 && m==0.
  - nan: e==255 && m!=0.
- Exponent arithmetic:
  - exp_sum = Ea + Eb − 127, computed 10-bit signed.
  - carry = (raw_prod[30:23] == (exp_sum+1)[7:0]). This detects the multiplier's normalisation shift.
  - exp_fin = exp_sum + carry.
- Sign: sign = A[31]^B[31], recomputed here.
- Result priority (first match wins):
  1. Either operand NaN, or inf×(zero/denorm): result=QNAN_PATTERN, invalid=1.
  2. Either operand inf: {sign, 8'hFF, 23'h0}.
  3. Either operand zero or denorm: {sign, 31'h0}; denorm_flush=1 if any denorm.
  4. exp_fin ≥ 255: {sign, 8'hFF, 23'h0}, overflow=1.
  5. exp_fin ≤ 0: {sign, 31'h0}, underflow=1.
  6. Otherwise: {sign, raw_prod[30:0]}.
- flags must be zero whenever no condition applies.
- Held outputs remain stable while out_valid && !out_ready.

Optional Feature:
- Macro: FP_MUL_STICKY_FLAGS_EN.
- Defined:
  - Adds input flags_clr (1) and output sticky_flags (4).
  - sticky_flags ORs in flags on each output handshake.
  - sticky_flags is cleared by rst or flags_clr.
  - If flags_clr coincides with a handshake, the cleared value is replaced by the new flags.
  - sticky_flags reset value is 0.
- Undefined: neither port exists and there is no sticky state. Per-result flags are unchanged.

Test Plan:
- 2.0×3.0: op_a=40000000, op_b=40400000, raw_prod=40C00000, out_ready=1 → result=40C00000, flags=0, out_valid exactly 2 cycles after acceptance.
- inf×0: op_a=7F800000, op_b=00000000, any raw_prod → result=7FC00000, flags=1000. Also op_a=FF800000 × op_b=C0000000 → result=7F800000, flags=0.
- Overflow/underflow:
  - 7F000000×7F000000 → 7F800000, flags=0100.
  - 00800000×00800000 → 00000000, flags=0010.
  - 80000001×3F800000 → 80000000, flags=0001.
- Backpressure: 4 back-to-back valid inputs with out_ready=0 for 5 cycles → in_ready low after 2 accepts; outputs stable; all 4 results delivered in order once out_ready=1.
- Reset mid-flight: assert rst for 1 cycle with both stages full → next cycle out_valid=0 and in_ready=1; the next accepted input is produced 2 cycles later with no stale data.
- Sticky flags (macro defined): overflow case then underflow case → sticky_flags=0110; pulse flags_clr → 0000.

Source files
------------

// File: rtl/fp_mul_result_stage.sv
// fp_mul_result_stage
//   Registered back end for the single-precision Vedic FP multiplier. Takes the
//   raw product with its operands and applies IEEE-754 special-case handling
//   (NaN, inf, zero, denormal flush, overflow, underflow) across a 2-stage
//   valid/ready pipeline.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  input handshake; in_ready is combinational
//   op_a, op_b      IEEE single operands
//   raw_prod        combinational multiplier output for op_a*op_b
//   out_valid/ready output handshake
//   result          corrected product (driven from the S2 register)
//   flags           {invalid, overflow, underflow, denorm_flush}
//
// Optional (FP_MUL_STICKY_FLAGS_EN defined)
//   flags_clr       clears sticky_flags; flags from a coincident handshake
//                   still land in the cleared value
//   sticky_flags    OR of flags over all consumed results
module fp_mul_result_stage #(
   parameter logic [31:0] QNAN_PATTERN = 32'h7FC00000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic [31:0] raw_prod,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic [3:0]  flags
`ifdef FP_MUL_STICKY_FLAGS_EN
   ,
   input  logic        flags_clr,
   output logic [3:0]  sticky_flags
`endif
);

   typedef struct packed {
      logic zero;
      logic den;
      logic inf;
      logic nan;
   } fp_class_t;

   function automatic fp_class_t classify(input logic [31:0] x);
      fp_class_t c;
      c.zero = (x[30:23] == 8'h00) && (x[22:0] == 23'h0);
      c.den  = (x[30:23] == 8'h00) && (x[22:0] != 23'h0);
      c.inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
      c.nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
      return c;
   endfunction

   // The multiplier's own sign bit is ignored; sign is rebuilt from operands.
   logic unused_raw_sign;
   assign unused_raw_sign = raw_prod[31];

   // ---------------- flow control ----------------
   logic s1_valid, s2_valid, s1_adv, s2_adv;

   assign s2_adv   = !s2_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;

   // ---------------- S1: capture + classify ----------------
   logic        s1_sign;
   logic [7:0]  s1_ea, s1_eb;
   logic [30:0] s1_raw;
   fp_class_t   s1_ca, s1_cb;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sign <= op_a[31] ^ op_b[31];
            s1_ea   <= op_a[30:23];
            s1_eb   <= op_b[30:23];
            s1_raw  <= raw_prod[30:0];
            s1_ca   <= classify(op_a);
            s1_cb   <= classify(op_b);
         end
      end
   end

   // ---------------- S2: override selection ----------------
   logic signed [9:0] exp_sum, exp_inc, exp_fin;
   logic              carry;
   logic              any_nan, any_inf, any_zero, any_den, inv_mul;
   logic [31:0]       nxt_result;
   logic [3:0]        nxt_flags;

   always_comb begin
      // Biased exponents never leave [-127, 383], so 10 signed bits suffice.
      exp_sum = signed'({2'b00, s1_ea}) + signed'({2'b00, s1_eb}) - 10'sd127;
      exp_inc = exp_sum + 10'sd1;
      // The multiplier bumps the exponent when the mantissa product is >= 2;
      // spot that by matching its exponent field against exp_sum+1.
      carry   = (s1_raw[30:23] == exp_inc[7:0]);
      exp_fin = exp_sum + (carry ? 10'sd1 : 10'sd0);

      any_nan  = s1_ca.nan  || s1_cb.nan;
      any_inf  = s1_ca.inf  || s1_cb.inf;
      any_zero = s1_ca.zero || s1_cb.zero;
      any_den  = s1_ca.den  || s1_cb.den;
      // Denormals are flushed before the inf check, so inf*denorm is inf*0.
      inv_mul  = (s1_ca.inf && (s1_cb.zero || s1_cb.den)) ||
                 (s1_cb.inf && (s1_ca.zero || s1_ca.den));

      nxt_result = {s1_sign, s1_raw};
      nxt_flags  = 4'b0000;
      if (any_nan || inv_mul) begin
         nxt_result = QNAN_PATTERN;
         nxt_flags  = 4'b1000;
      end else if (any_inf) begin
         nxt_result = {s1_sign, 8'hFF, 23'h0};
      end else if (any_zero || any_den) begin
         nxt_result = {s1_sign, 31'h0};
         nxt_flags  = {3'b000, any_den};
      end else if (exp_fin >= 10'sd255) begin
         nxt_result = {s1_sign, 8'hFF, 23'h0};
         nxt_flags  = 4'b0100;
      end else if (exp_fin <= 10'sd0) begin
         nxt_result = {s1_sign, 31'h0};
         nxt_flags  = 4'b0010;
      end
   end

   logic [31:0] s2_result;
   logic [3:0]  s2_flags;

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid  <= 1'b0;
         s2_result <= 32'h0;
         s2_flags  <= 4'h0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_result <= nxt_result;
            s2_flags  <= nxt_flags;
         end
      end
   end

   assign out_valid = s2_valid;
   assign result    = s2_result;
   assign flags     = s2_flags;

`ifdef FP_MUL_STICKY_FLAGS_EN
   logic out_hs;
   assign out_hs = s2_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         sticky_flags <= 4'h0;
      end else if (flags_clr || out_hs) begin
         sticky_flags <= (flags_clr ? 4'h0 : sticky_flags) |
                         (out_hs ? s2_flags : 4'h0);
      end
   end
`endif

endmodule
